out_i2s: RTL and testbench
==========================

OUT_I2S -- requirements
Module: out_i2s

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample width per channel, two's complement.
REQ-002 SHALL have parameter SLOT_WIDTH, default 32: BCLK periods per channel slot; SHALL be at least DATA_WIDTH+1.
REQ-003 SHALL have parameter BCLK_DIV, default 2: clk cycles per BCLK half-period; SHALL be at least 1.
REQ-004 SHALL have port clk, input, 1: system clock; all state on rising edge.
REQ-005 SHALL have port ADCLRC, input, 1: reset ADCLRC, asynchronous, active-low.
REQ-006 SHALL have port in_left_data, input, DATA_WIDTH: left sample.
REQ-007 SHALL have port in_right_data, input, DATA_WIDTH: right sample.
REQ-008 SHALL have port in_valid, input, 1: sample pair offered.
REQ-009 SHALL have port in_ready, output, 1: holding register empty; accept when in_valid && in_ready.
REQ-010 SHALL have port BCLK, output, 1: I2S bit clock, registered.
REQ-011 SHALL have port DACLRC, output, 1: word select; 0 = left slot, 1 = right slot.
REQ-012 SHALL have port DACDAT, output, 1: serial data, MSB first.
REQ-013 SHALL have port underrun, output, 1: one-clk pulse when a frame starts with no sample held.

Function
REQ-014 SHALL count div_cnt 0..BCLK_DIV-1 and toggle BCLK on each wrap, giving a BCLK period of 2*BCLK_DIV clk.
REQ-015 SHALL define a "fall event" as the clk cycle in which BCLK is driven from 1 to 0. DACLRC and DACDAT SHALL change only on fall events.
REQ-016 SHALL keep bit_cnt 0..2*SLOT_WIDTH-1 and advance it by 1 with wrap on each fall event.
REQ-017 SHALL drive DACLRC = 1 exactly when bit_cnt >= SLOT_WIDTH.
REQ-018 SHALL use I2S one-bit delay. At slot position p = bit_cnt mod SLOT_WIDTH, DACDAT SHALL carry channel bit DATA_WIDTH-p for p in 1..DATA_WIDTH, and 0 at every other position.
REQ-019 SHALL keep a holding register (left, right) and a full flag; in_ready SHALL equal !full, combinationally.
REQ-020 SHALL, on a handshake, capture in_left_data/in_right_data into the holding register and set full the next clk.
REQ-021 SHALL, on the fall event where bit_cnt wraps to 0, copy the holding register to the shift registers and clear full if full. If not full, it SHALL load zeros and pulse underrun for exactly one clk.
REQ-022 SHALL never accept and consume in the same clk, since accept requires !full and consume requires full; a held sample SHALL NOT be overwritten.
REQ-023 Latency: an accepted pair SHALL emit its left MSB at the second fall event of the next frame, bit_cnt = 1.
REQ-024 SHALL consume exactly one sample pair per frame when in_valid is held high continuously.

Reset
REQ-025 SHALL, while ADCLRC = 0, force BCLK=0, DACLRC=0, DACDAT=0, underrun=0, div_cnt=0, full=0, shift registers=0 and bit_cnt=2*SLOT_WIDTH-1, regardless of clk.
REQ-026 SHALL hold in_ready = 1 during and after reset.
REQ-027 SHALL make the first fall event after reset release wrap bit_cnt to 0 and perform a frame load.
REQ-028 SHALL discard any partially sent frame and any held sample when reset is asserted mid-frame.

Structure
REQ-029 SHALL take DATA_WIDTH/SLOT_WIDTH defaults and the LRC polarity constant (LEFT = 0) from shared package i2s_pkg, common with the receiver.
REQ-030 SHALL place the BCLK divider, bit_cnt and fall-event strobe in one sub-module, i2s_clkgen. Holding, shift and output logic SHALL remain in out_i2s.

Verification (DATA_WIDTH=16, SLOT_WIDTH=32, BCLK_DIV=2)
REQ-031 Reset: hold ADCLRC=0 for 10 clk with clk running -> BCLK=DACLRC=DACDAT=underrun=0, in_ready=1; release -> BCLK period 4 clk, frame 256 clk.
REQ-032 Single pair: accept L=16'hA5C3, R=16'h1234 before the first wrap -> DACDAT is 0 at p=0, then A5C3 MSB-first at p=1..16, then 0 at p=17..31; then 1234 in the right slot with DACLRC=1; underrun stays 0.
REQ-033 Underrun: no in_valid for 3 frames -> DACDAT all 0; underrun pulses one clk at each bit_cnt wrap, 3 pulses total.
REQ-034 Back-to-back: in_valid held high with pairs 0x0001/0x8000, 0x7FFF/0xFFFF -> in_ready low between accept and frame load; each pair is sent exactly once, in order, with no underrun.
REQ-035 Mid-frame reset: assert ADCLRC=0 at bit_cnt=20 with a sample held -> all outputs return to reset values within the same clk; after release the first frame is zero and underrun pulses once.
REQ-036 LRC timing: DACLRC rises exactly at the fall event with bit_cnt=32, falls at bit_cnt=0, and never toggles between fall events.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S defaults and word-select polarity
package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 16;
    localparam int I2S_SLOT_WIDTH = 32;

    typedef enum logic {
        LRC_LEFT  = 1'b0,
        LRC_RIGHT = 1'b1
    } lrc_e;

endpackage

// File: rtl/out_i2s_if.sv
// rtl/out_i2s_if.sv - stereo sample pair handshake into the I2S transmitter
interface out_i2s_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic [DATA_WIDTH-1:0] in_left_data;
    logic [DATA_WIDTH-1:0] in_right_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_left_data,
        output in_right_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_left_data,
        input  in_right_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - BCLK divider, frame bit counter and fall-event strobe
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter int BCLK_DIV   = 2
) (
    input  logic                            clk,
    input  logic                            ADCLRC,
    output logic                            bclk,
    output logic                            fall,
    output logic                            frame_start,
    output logic [$clog2(2*SLOT_WIDTH)-1:0] bit_cnt_nxt
);

    localparam int CNT_W = $clog2(2*SLOT_WIDTH);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*SLOT_WIDTH - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             div_wrap;

    assign div_wrap    = (div_cnt == DIV_LAST);
    assign fall        = div_wrap && bclk;
    assign frame_start = fall && (bit_cnt == CNT_LAST);
    assign bit_cnt_nxt = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;

    // bit_cnt parks at the last position so the first fall after reset opens a frame
    always_ff @(posedge clk or negedge ADCLRC) begin
        if (!ADCLRC) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= CNT_LAST;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bclk <= ~bclk;
            end
            if (fall) begin
                bit_cnt <= bit_cnt_nxt;
            end
        end
    end

endmodule

// File: rtl/out_i2s.sv
// rtl/out_i2s.sv - I2S transmitter: one-deep sample holding register feeding left/right shifters
module out_i2s
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter int BCLK_DIV   = 2
) (
    input  logic      clk,
    input  logic      ADCLRC,
    out_i2s_if.slave  s_in,
    output logic      BCLK,
    output logic      DACLRC,
    output logic      DACDAT,
    output logic      underrun
);

    localparam int CNT_W = $clog2(2*SLOT_WIDTH);
    localparam logic [CNT_W-1:0] SLOT_POS  = CNT_W'(SLOT_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH);

    logic                  fall;
    logic                  frame_start;
    logic [CNT_W-1:0]      bit_cnt_nxt;
    logic [CNT_W-1:0]      pos;
    logic                  right_slot;
    logic                  data_slot;
    logic                  full;
    logic                  accept;
    logic [DATA_WIDTH-1:0] hold_left;
    logic [DATA_WIDTH-1:0] hold_right;
    logic [DATA_WIDTH-1:0] left_sr;
    logic [DATA_WIDTH-1:0] right_sr;

    i2s_clkgen #(
        .SLOT_WIDTH (SLOT_WIDTH),
        .BCLK_DIV   (BCLK_DIV)
    ) u_clkgen (
        .clk         (clk),
        .ADCLRC      (ADCLRC),
        .bclk        (BCLK),
        .fall        (fall),
        .frame_start (frame_start),
        .bit_cnt_nxt (bit_cnt_nxt)
    );

    assign s_in.in_ready = !full;
    assign accept        = s_in.in_valid && !full;

    // Slot position of the bit that goes out at this fall; position 0 is the one-bit I2S delay
    assign right_slot = (bit_cnt_nxt >= SLOT_POS);
    assign pos        = right_slot ? bit_cnt_nxt - SLOT_POS : bit_cnt_nxt;
    assign data_slot  = (pos != '0) && (pos <= DATA_LAST);

    // A frame start with an empty register can coincide with an accept; that sample waits a frame
    always_ff @(posedge clk or negedge ADCLRC) begin
        if (!ADCLRC) begin
            full       <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
        end else if (accept) begin
            full       <= 1'b1;
            hold_left  <= s_in.in_left_data;
            hold_right <= s_in.in_right_data;
        end else if (frame_start) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge ADCLRC) begin
        if (!ADCLRC) begin
            left_sr  <= '0;
            right_sr <= '0;
            DACLRC   <= LRC_LEFT;
            DACDAT   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame_start && !full;
            if (frame_start) begin
                left_sr  <= full ? hold_left  : '0;
                right_sr <= full ? hold_right : '0;
            end
            if (fall) begin
                DACLRC <= right_slot ? LRC_RIGHT : LRC_LEFT;
                DACDAT <= 1'b0;
                if (data_slot && !right_slot) begin
                    DACDAT  <= left_sr[DATA_WIDTH-1];
                    left_sr <= left_sr << 1;
                end else if (data_slot && right_slot) begin
                    DACDAT   <= right_sr[DATA_WIDTH-1];
                    right_sr <= right_sr << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_out_i2s.sv
// tb/tb_out_i2s.sv - directed self-checking bench for out_i2s
module tb_out_i2s;

    logic clk = 1'b0;
    logic ADCLRC = 1'b0;
    logic BCLK;
    logic DACLRC;
    logic DACDAT;
    logic underrun;

    out_i2s_if #(.DATA_WIDTH(16)) sif ();

    out_i2s #(
        .DATA_WIDTH (16),
        .SLOT_WIDTH (32),
        .BCLK_DIV   (2)
    ) dut (
        .clk      (clk),
        .ADCLRC   (ADCLRC),
        .s_in     (sif),
        .BCLK     (BCLK),
        .DACLRC   (DACLRC),
        .DACDAT   (DACDAT),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Line tracker: frame position is derived only from observed BCLK falling edges
    int          clk_cnt = 0;
    int          tb_pos = 63;
    int          frame_cnt = 0;
    int          under_cnt = 0;
    int          glitch_cnt = 0;
    int          period_bad = 0;
    int          last_fall = 0;
    int          last_frame = 0;
    int          frame_len = 0;
    bit          have_fall = 0;
    bit          have_frame = 0;
    logic        prev_bclk = 0;
    logic        prev_lrc = 0;
    logic        prev_dat = 0;
    logic [63:0] cur_dat = '0;
    logic [63:0] cur_lrc = '0;
    logic [63:0] frame_dat = '0;
    logic [63:0] frame_lrc = '0;

    always @(negedge clk) begin
        clk_cnt = clk_cnt + 1;
        if (!ADCLRC) begin
            tb_pos     = 63;
            have_fall  = 0;
            have_frame = 0;
            prev_bclk  = 0;
            prev_lrc   = 0;
            prev_dat   = 0;
        end else begin
            if (underrun) under_cnt = under_cnt + 1;
            if (prev_bclk && !BCLK) begin
                if (have_fall && (clk_cnt - last_fall) != 4) period_bad = period_bad + 1;
                last_fall = clk_cnt;
                have_fall = 1;
                tb_pos = (tb_pos + 1) % 64;
                cur_dat[tb_pos] = DACDAT;
                cur_lrc[tb_pos] = DACLRC;
                if (tb_pos == 63) begin
                    frame_dat = cur_dat;
                    frame_lrc = cur_lrc;
                    if (have_frame) frame_len = clk_cnt - last_frame;
                    last_frame = clk_cnt;
                    have_frame = 1;
                    frame_cnt = frame_cnt + 1;
                end
            end else if (DACLRC !== prev_lrc || DACDAT !== prev_dat) begin
                glitch_cnt = glitch_cnt + 1;
            end
            prev_bclk = BCLK;
            prev_lrc  = DACLRC;
            prev_dat  = DACDAT;
        end
    end

    function automatic logic [63:0] exp_dat(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] e;
        e = '0;
        for (int p = 1; p <= 16; p++) begin
            e[p]      = l[16-p];
            e[32 + p] = r[16-p];
        end
        return e;
    endfunction

    logic [63:0] lrc_exp;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frame(input string name);
        int start;
        int k;
        start = frame_cnt;
        k = 0;
        while (frame_cnt == start && k < 600) begin
            step();
            k++;
        end
        n_checks++;
        if (frame_cnt == start) begin
            n_fail++;
            $display("FAIL %s: no frame completed within %0d clk, required within 600", name, k);
        end
    endtask

    task automatic test_reset();
        ADCLRC = 1'b0;
        repeat (10) step();
        n_checks++; if (BCLK !== 1'b0)     begin n_fail++; $display("FAIL reset_bclk: got %b want 0", BCLK); end
        n_checks++; if (DACLRC !== 1'b0)   begin n_fail++; $display("FAIL reset_daclrc: got %b want 0", DACLRC); end
        n_checks++; if (DACDAT !== 1'b0)   begin n_fail++; $display("FAIL reset_dacdat: got %b want 0", DACDAT); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        n_checks++; if (sif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", sif.in_ready); end
    endtask

    task automatic test_single_pair();
        int u0;
        ADCLRC = 1'b1;
        u0 = under_cnt;
        sif.in_left_data  = 16'hA5C3;
        sif.in_right_data = 16'h1234;
        sif.in_valid      = 1'b1;
        step();
        sif.in_valid = 1'b0;
        n_checks++; if (sif.in_ready !== 1'b0) begin n_fail++; $display("FAIL single_in_ready_after_accept: got %b want 0", sif.in_ready); end
        wait_frame("single_frame");
        n_checks++; if (frame_dat !== exp_dat(16'hA5C3, 16'h1234)) begin n_fail++; $display("FAIL single_dat: got %h want %h", frame_dat, exp_dat(16'hA5C3, 16'h1234)); end
        n_checks++; if (frame_lrc !== lrc_exp) begin n_fail++; $display("FAIL single_lrc: got %h want %h", frame_lrc, lrc_exp); end
        n_checks++; if (under_cnt - u0 != 0) begin n_fail++; $display("FAIL single_underrun: got %0d pulses want 0", under_cnt - u0); end
    endtask

    task automatic test_underrun();
        int u0;
        u0 = under_cnt;
        for (int f = 0; f < 3; f++) begin
            wait_frame("underrun_frame");
            n_checks++; if (frame_dat !== 64'h0) begin n_fail++; $display("FAIL underrun_dat%0d: got %h want 0", f, frame_dat); end
        end
        n_checks++; if (under_cnt - u0 != 3) begin n_fail++; $display("FAIL underrun_pulses: got %0d clk high want 3", under_cnt - u0); end
        n_checks++; if (frame_len != 256) begin n_fail++; $display("FAIL frame_len: got %0d clk want 256", frame_len); end
    endtask

    task automatic test_back_to_back();
        int u0;
        int k;
        u0 = under_cnt;
        sif.in_left_data  = 16'h0001;
        sif.in_right_data = 16'h8000;
        sif.in_valid      = 1'b1;
        step();
        n_checks++; if (sif.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low0: got %b want 0", sif.in_ready); end
        sif.in_left_data  = 16'h7FFF;
        sif.in_right_data = 16'hFFFF;
        k = 0;
        while (sif.in_ready !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        n_checks++; if (sif.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_return: got %b want 1 within 50 clk", sif.in_ready); end
        step();
        sif.in_valid = 1'b0;
        n_checks++; if (sif.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low1: got %b want 0", sif.in_ready); end
        wait_frame("b2b_frame0");
        n_checks++; if (frame_dat !== exp_dat(16'h0001, 16'h8000)) begin n_fail++; $display("FAIL b2b_dat0: got %h want %h", frame_dat, exp_dat(16'h0001, 16'h8000)); end
        wait_frame("b2b_frame1");
        n_checks++; if (frame_dat !== exp_dat(16'h7FFF, 16'hFFFF)) begin n_fail++; $display("FAIL b2b_dat1: got %h want %h", frame_dat, exp_dat(16'h7FFF, 16'hFFFF)); end
        n_checks++; if (frame_lrc !== lrc_exp) begin n_fail++; $display("FAIL b2b_lrc: got %h want %h", frame_lrc, lrc_exp); end
        n_checks++; if (under_cnt - u0 != 0) begin n_fail++; $display("FAIL b2b_underrun: got %0d pulses want 0", under_cnt - u0); end
    endtask

    task automatic test_mid_frame_reset();
        int u0;
        int k;
        k = 0;
        while (tb_pos != 19 && k < 400) begin step(); k++; end
        sif.in_left_data  = 16'h5A5A;
        sif.in_right_data = 16'hC3C3;
        sif.in_valid      = 1'b1;
        step();
        sif.in_valid = 1'b0;
        k = 0;
        while (tb_pos != 20 && k < 20) begin step(); k++; end
        n_checks++; if (tb_pos != 20 || sif.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_setup: pos %0d ready %b want pos 20 ready 0", tb_pos, sif.in_ready); end
        ADCLRC = 1'b0;
        #1;
        n_checks++; if (BCLK !== 1'b0)     begin n_fail++; $display("FAIL midrst_bclk: got %b want 0", BCLK); end
        n_checks++; if (DACLRC !== 1'b0)   begin n_fail++; $display("FAIL midrst_daclrc: got %b want 0", DACLRC); end
        n_checks++; if (DACDAT !== 1'b0)   begin n_fail++; $display("FAIL midrst_dacdat: got %b want 0", DACDAT); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL midrst_underrun: got %b want 0", underrun); end
        n_checks++; if (sif.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", sif.in_ready); end
        repeat (10) step();
        ADCLRC = 1'b1;
        u0 = under_cnt;
        wait_frame("midrst_frame");
        n_checks++; if (frame_dat !== 64'h0) begin n_fail++; $display("FAIL midrst_dat: got %h want 0", frame_dat); end
        n_checks++; if (under_cnt - u0 != 1) begin n_fail++; $display("FAIL midrst_underrun_pulses: got %0d want 1", under_cnt - u0); end
    endtask

    task automatic test_lrc_timing();
        logic b0;
        logic b31;
        logic b32;
        b0  = frame_lrc[0];
        b31 = frame_lrc[31];
        b32 = frame_lrc[32];
        n_checks++; if (b0 !== 1'b0)  begin n_fail++; $display("FAIL lrc_pos0: got %b want 0", b0); end
        n_checks++; if (b31 !== 1'b0) begin n_fail++; $display("FAIL lrc_pos31: got %b want 0", b31); end
        n_checks++; if (b32 !== 1'b1) begin n_fail++; $display("FAIL lrc_pos32: got %b want 1", b32); end
        n_checks++; if (glitch_cnt != 0) begin n_fail++; $display("FAIL lrc_dat_between_falls: got %0d changes want 0", glitch_cnt); end
        n_checks++; if (period_bad != 0) begin n_fail++; $display("FAIL bclk_period: got %0d bad periods want 0", period_bad); end
    endtask

    initial begin
        lrc_exp           = {32'hFFFF_FFFF, 32'h0000_0000};
        sif.in_valid      = 1'b0;
        sif.in_left_data  = '0;
        sif.in_right_data = '0;
        test_reset();
        test_single_pair();
        test_underrun();
        test_back_to_back();
        test_mid_frame_reset();
        test_lrc_timing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded 2000000 time units");
        $fatal(1, "watchdog");
    end

endmodule
